// File: rtl/avr_tx_arbiter_if.sv
// Requester and AVR transmit channel bundle for avr_tx_arbiter.
// The master side is the requesters plus avr_interface; the slave side is the arbiter.
interface avr_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_data;
  logic               new_tx_data;
  logic               tx_busy;
  logic               pkt_done;
  logic               pkt_abort;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, new_tx_data,
    input  pkt_done, pkt_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, new_tx_data,
    output pkt_done, pkt_abort
  );
endinterface

// File: rtl/avr_tx_arbiter.sv
// Packet-level round-robin arbiter for the AVR serial transmit channel.
// Frames are: 0xA<id> header, payload bytes, XOR checksum (inverted on abort).
module avr_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 50000
) (
  input logic           clk,
  input logic           rst_n,
  avr_tx_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] TRAILER = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] cur_id;
  logic [IW-1:0] last_id;
  logic [IW-1:0] nxt_id;
  logic [IW-1:0] ix;
  logic          found;
  logic [7:0]    csum;
  logic [7:0]    hdr;
  logic [7:0]    cur_byte;
  logic [CW-1:0] count;
  logic [SW-1:0] stall;
  logic          abort_f;
  logic          can_send;
  logic          cur_valid;
  logic          cur_last;

  // One idle cycle between strobes lets avr_interface raise tx_busy.
  assign can_send  = !bus.tx_busy && !bus.new_tx_data;
  assign cur_valid = bus.req_valid[cur_id];
  assign cur_last  = bus.req_last[cur_id];
  assign cur_byte  = bus.req_data[{cur_id, 3'b000} +: 8];
  assign hdr       = {4'hA, 4'(cur_id)};

  always_comb begin
    bus.req_ready = '0;
    if (state == PAYLOAD && can_send)
      bus.req_ready[cur_id] = 1'b1;
  end

  // Search starts just after the previous owner.
  always_comb begin
    nxt_id = '0;
    found  = 1'b0;
    ix     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      ix = IW'((int'(last_id) + k) % N_REQ);
      if (!found && bus.req_valid[ix]) begin
        found  = 1'b1;
        nxt_id = ix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cur_id          <= '0;
      last_id         <= IW'(N_REQ - 1);
      csum            <= '0;
      count           <= '0;
      stall           <= '0;
      abort_f         <= 1'b0;
      bus.grant       <= '0;
      bus.tx_data     <= '0;
      bus.new_tx_data <= 1'b0;
      bus.pkt_done    <= 1'b0;
      bus.pkt_abort   <= 1'b0;
    end else begin
      bus.new_tx_data <= 1'b0;
      bus.pkt_done    <= 1'b0;
      bus.pkt_abort   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            bus.grant         <= '0;
            bus.grant[nxt_id] <= 1'b1;
            cur_id            <= nxt_id;
            csum              <= '0;
            count             <= '0;
            stall             <= '0;
            state             <= HEADER;
          end
        end
        HEADER: begin
          if (can_send) begin
            bus.tx_data     <= hdr;
            bus.new_tx_data <= 1'b1;
            csum            <= csum ^ hdr;
            state           <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (can_send && cur_valid) begin
            bus.tx_data     <= cur_byte;
            bus.new_tx_data <= 1'b1;
            csum            <= csum ^ cur_byte;
            count           <= count + 1'b1;
            stall           <= '0;
            if (cur_last || count == CW'(MAX_LEN - 1))
              state <= TRAILER;
          end else if (!cur_valid && !bus.tx_busy) begin
            if (stall == SW'(TIMEOUT - 1)) begin
              abort_f <= 1'b1;
              state   <= TRAILER;
            end else begin
              stall <= stall + 1'b1;
            end
          end
        end
        TRAILER: begin
          if (can_send) begin
            bus.tx_data     <= abort_f ? ~csum : csum;
            bus.new_tx_data <= 1'b1;
            bus.pkt_done    <= !abort_f;
            bus.pkt_abort   <= abort_f;
            bus.grant       <= '0;
            last_id         <= cur_id;
            abort_f         <= 1'b0;
            state           <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Directed bench for avr_tx_arbiter: framing, round-robin, back-pressure,
// stall abort, truncation and asynchronous reset.
module tb_avr_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avr_tx_arbiter_if #(.N_REQ(4)) bus();

  avr_tx_arbiter #(
    .N_REQ  (4),
    .MAX_LEN(4),
    .TIMEOUT(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [8:0] mem [4][32];
  int         hd [4] = '{0, 0, 0, 0};
  int         tl [4] = '{0, 0, 0, 0};
  int         fgen = 0;
  int         fseen = 0;
  logic [3:0] acc;

  logic [7:0] lg_b [128];
  logic       lg_d [128];
  logic       lg_a [128];
  int         lg_t [128];
  int         lg_n = 0;

  // Requester models: pop on accept, present the next queued byte.
  always @(posedge clk) begin
    cyc++;
    acc = bus.req_ready & bus.req_valid;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] === 1'b1) hd[i]++;
      if (fgen != fseen) hd[i] = tl[i];
      bus.req_valid[i]       = (hd[i] != tl[i]);
      bus.req_data[8*i +: 8] = mem[i][hd[i] % 32][7:0];
      bus.req_last[i]        = mem[i][hd[i] % 32][8];
    end
    fseen = fgen;
  end

  always @(negedge clk) begin
    if (bus.new_tx_data === 1'b1 && lg_n < 128) begin
      lg_b[lg_n] = bus.tx_data;
      lg_d[lg_n] = bus.pkt_done;
      lg_a[lg_n] = bus.pkt_abort;
      lg_t[lg_n] = cyc;
      lg_n++;
    end
  end

  task automatic push(input int id, input logic [7:0] d, input logic l);
    mem[id][tl[id] % 32] = {l, d};
    tl[id]++;
  endtask

  task automatic wait_strobes(input int base, input int n,
                              input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (lg_n >= base + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({bus.tx_data, bus.new_tx_data} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_tx: got %h/%b, want 00/0",
               bus.tx_data, bus.new_tx_data);
    end
    n_run++;
    if ({bus.grant, bus.req_ready, bus.pkt_done, bus.pkt_abort} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_ctl: grant %b ready %b done %b abort %b, want zeros",
               bus.grant, bus.req_ready, bus.pkt_done, bus.pkt_abort);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int b;
    bit ok;
    logic [7:0] exp [4];
    exp = '{8'hA0, 8'h11, 8'h22, 8'h93};
    b = lg_n;
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b1);
    wait_strobes(b, 4, 60, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: got %0d strobes, want 4", lg_n - b);
    end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (lg_b[b+k] !== exp[k]) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %h, want %h", k, lg_b[b+k], exp[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      n_run++;
      if (lg_t[b+k] - lg_t[b+k-1] !== 2) begin
        n_fail++;
        $display("FAIL single_gap%0d: got %0d, want 2", k,
                 lg_t[b+k] - lg_t[b+k-1]);
      end
    end
    n_run++;
    if ({lg_d[b+3], lg_d[b+2], lg_d[b+1], lg_d[b],
         lg_a[b+3], lg_a[b+2], lg_a[b+1], lg_a[b]} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL single_flags: got done %b%b%b%b abort %b%b%b%b, want 1000 0000",
               lg_d[b+3], lg_d[b+2], lg_d[b+1], lg_d[b],
               lg_a[b+3], lg_a[b+2], lg_a[b+1], lg_a[b]);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_grant: got %b, want 0000", bus.grant);
    end
  endtask

  task automatic test_round_robin();
    int b;
    bit ok;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) push(k, 8'(8'h10 + k), 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b = lg_n;
    wait_strobes(b, 12, 120, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d strobes, want 12", lg_n - b);
    end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (lg_b[b+3*k] !== 8'(8'hA0 + k)) begin
        n_fail++;
        $display("FAIL rr_hdr%0d: got %h, want %h", k, lg_b[b+3*k], 8'(8'hA0 + k));
      end
      n_run++;
      if (lg_b[b+3*k+2] !== 8'hB0) begin
        n_fail++;
        $display("FAIL rr_csum%0d: got %h, want b0", k, lg_b[b+3*k+2]);
      end
    end
    b = lg_n;
    push(1, 8'h33, 1'b1);
    wait_strobes(b, 3, 40, ok);
    b = lg_n;
    push(0, 8'h44, 1'b1);
    push(2, 8'h66, 1'b1);
    wait_strobes(b, 6, 60, ok);
    n_run++;
    if ({lg_b[b], lg_b[b+1], lg_b[b+3], lg_b[b+4]} !== 32'hA2_66_A0_44) begin
      n_fail++;
      $display("FAIL rr_order: got %h %h %h %h, want a2 66 a0 44",
               lg_b[b], lg_b[b+1], lg_b[b+3], lg_b[b+4]);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int viol;
    bit ok;
    b = lg_n;
    push(3, 8'h5A, 1'b1);
    wait_strobes(b, 1, 30, ok);
    bus.tx_busy = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.new_tx_data !== 1'b0 || bus.req_ready !== 4'b0000) viol++;
    end
    n_run++;
    if (viol !== 0 || lg_n !== b + 1) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d violations %0d strobes, want 0 and 1",
               viol, lg_n - b);
    end
    #1 bus.tx_busy = 1'b0;
    wait_strobes(b, 2, 1, ok);
    n_run++;
    if (!ok || lg_b[b+1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL bp_release: got ok=%b byte %h, want 1 and 5a", ok, lg_b[b+1]);
    end
    wait_strobes(b, 3, 10, ok);
    n_run++;
    if (lg_b[b+2] !== 8'hF9 || lg_d[b+2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_trailer: got %h done %b, want f9 done 1",
               lg_b[b+2], lg_d[b+2]);
    end
  endtask

  task automatic test_stall_abort();
    int b;
    bit ok;
    b = lg_n;
    push(1, 8'h55, 1'b0);
    wait_strobes(b, 2, 30, ok);
    n_run++;
    if ({lg_b[b], lg_b[b+1]} !== 16'hA1_55) begin
      n_fail++;
      $display("FAIL stall_head: got %h %h, want a1 55", lg_b[b], lg_b[b+1]);
    end
    wait_strobes(b, 3, 60, ok);
    n_run++;
    if (!ok || lg_b[b+2] !== 8'h0B || lg_a[b+2] !== 1'b1 || lg_d[b+2] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_trailer: got ok=%b %h abort %b done %b, want 0b abort 1 done 0",
               ok, lg_b[b+2], lg_a[b+2], lg_d[b+2]);
    end
    n_run++;
    if (lg_t[b+2] - lg_t[b+1] < 20 || lg_t[b+2] - lg_t[b+1] > 24) begin
      n_fail++;
      $display("FAIL stall_delay: got %0d cycles, want 20..24",
               lg_t[b+2] - lg_t[b+1]);
    end
    repeat (2) @(negedge clk);
    n_run++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_grant: got %b, want 0000", bus.grant);
    end
  endtask

  task automatic test_truncation();
    int b;
    bit ok;
    logic [7:0] exp [10];
    exp = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA6,
            8'hA2, 8'h05, 8'h06, 8'hA1};
    b = lg_n;
    for (int k = 0; k < 6; k++) push(2, 8'(k + 1), k == 5);
    wait_strobes(b, 10, 100, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL trunc_timeout: got %0d strobes, want 10", lg_n - b);
    end
    for (int k = 0; k < 10; k++) begin
      n_run++;
      if (lg_b[b+k] !== exp[k]) begin
        n_fail++;
        $display("FAIL trunc_byte%0d: got %h, want %h", k, lg_b[b+k], exp[k]);
      end
    end
    n_run++;
    if ({lg_d[b+5], lg_d[b+9], lg_d[b+4]} !== 3'b110) begin
      n_fail++;
      $display("FAIL trunc_done: got %b%b%b, want 110",
               lg_d[b+5], lg_d[b+9], lg_d[b+4]);
    end
  endtask

  task automatic test_async_reset();
    int b;
    int b2;
    bit ok;
    b = lg_n;
    push(0, 8'h10, 1'b0);
    push(0, 8'h20, 1'b0);
    push(0, 8'h30, 1'b1);
    wait_strobes(b, 2, 30, ok);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.new_tx_data !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_tx: got %b/%h, want 0/00", bus.new_tx_data, bus.tx_data);
    end
    n_run++;
    if (bus.grant !== 4'b0000 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_grant: got %b/%b, want 0000/0000",
               bus.grant, bus.req_ready);
    end
    fgen++;
    repeat (4) @(negedge clk);
    n_run++;
    if (lg_n !== b + 2) begin
      n_fail++;
      $display("FAIL arst_no_trailer: got %0d strobes, want 2", lg_n - b);
    end
    rst_n = 1'b1;
    b2 = lg_n;
    push(3, 8'h77, 1'b1);
    push(0, 8'h88, 1'b1);
    wait_strobes(b2, 6, 60, ok);
    n_run++;
    if ({lg_b[b2], lg_b[b2+1], lg_b[b2+3], lg_b[b2+4]} !== 32'hA0_88_A3_77) begin
      n_fail++;
      $display("FAIL arst_first: got %h %h %h %h, want a0 88 a3 77",
               lg_b[b2], lg_b[b2+1], lg_b[b2+3], lg_b[b2+4]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.tx_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall_abort();
    test_truncation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/avr_tx_arbiter.md
# avr_tx_arbiter

Packet-level round-robin arbiter that shares the single AVR serial transmit channel (`tx_data` / `new_tx_data` / `tx_busy` of `avr_interface`) among up to `N_REQ` byte-stream requesters, such as `debugging`, flag telemetry and IMU dumps. It holds a grant for a whole packet and frames each packet with a source-ID header and an XOR checksum trailer. It aborts a packet whose owner stalls. It sits between the requesters and `avr_interface` in the `avionics` top level.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `MAX_LEN`, default 32: maximum payload bytes per packet.
- `TIMEOUT`, default 50000: stall limit in clk cycles, for a granted requester with `req_valid` low mid-packet.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: requester i has a payload byte available.
- `req_data` in 8*N_REQ: byte of requester i is in bits [8i+7:8i].
- `req_last` in N_REQ: the current byte of requester i ends its packet.
- `req_ready` out N_REQ: byte of requester i accepted this cycle, when `req_valid` is also high.
- `grant` out N_REQ: one-hot owner of the channel; all zero when idle.
- `tx_data` out 8: byte to `avr_interface`.
- `new_tx_data` out 1: one-cycle strobe, qualifies `tx_data`.
- `tx_busy` in 1: from `avr_interface`; the UART cannot take a byte.
- `pkt_done` out 1: one-cycle pulse when the trailer of a good packet is issued.
- `pkt_abort` out 1: one-cycle pulse when the trailer of an aborted packet is issued.

## Operation
- States:
  - IDLE: `grant`=0.
    - Any `req_valid` → pick the next set bit after `last_id` in round-robin order, load `grant`/`cur_id`, csum=0, count=0 → HEADER.
    - Requesters that already had a turn wait behind the others.
  - HEADER: when `can_send`, issue byte {4'hA, cur_id[3:0]}, csum ^= byte → PAYLOAD.
  - PAYLOAD:
    - `req_ready[cur_id]` = `can_send`; all other `req_ready` bits are 0.
    - On valid&ready: issue `req_data` of `cur_id`, csum ^= byte, count++, stall counter cleared.
    - Trailer condition: `req_last` or count reaches `MAX_LEN` → TRAILER.
    - `MAX_LEN` reached without `req_last` truncates the packet silently. The requester's remaining bytes start a new packet on its next grant.
    - `req_valid[cur_id]` low → stall counter++. Reaching `TIMEOUT` sets `abort_f` → TRAILER.
  - TRAILER: when `can_send`, issue csum, or ~csum when `abort_f`. Pulse `pkt_done` or `pkt_abort` in the same cycle as the strobe. `last_id`=cur_id, clear `abort_f` → IDLE.
- `can_send` = !`tx_busy` && !`new_tx_data`. This enforces at least one idle cycle between strobes, so `avr_interface` can raise `tx_busy`.
- "Issue" means `tx_data`/`new_tx_data` are registered: the strobe appears the cycle after the decision.
- Frame on the wire: header, 1..`MAX_LEN` payload bytes, checksum. The checksum is the XOR of the header and all payload bytes. A receiver detects an aborted packet by its inverted checksum.
- Grant changes only in IDLE; requesters never see a grant change mid-packet.
- `req_valid` of non-granted requesters is ignored and nothing is dropped; they hold their data.

## Timing
- Reset (`rst_n` low, async) clears:
  - outputs: `tx_data`=0, `new_tx_data`=0, `grant`=0, `req_ready`=0, `pkt_done`=0, `pkt_abort`=0;
  - internal state: state=IDLE, `last_id`=N_REQ-1 (so requester 0 wins first), csum=0, counters 0.
- Reset mid-packet abandons the frame with no trailer. The receiver resynchronises on the next 0xA_ header.
- Latency with `tx_busy` low throughout:
  - `req_valid` rises at cycle t → `grant` registered at t+1.
  - Header strobe at t+2.
  - First payload `req_ready` at t+3, its strobe at t+4.
  - Payload strobes every 2 cycles at best.
- `tx_busy` high holds all issue decisions. Outputs hold their values, and `req_ready` stays 0.
- `req_ready` is combinational from state, `tx_busy` and `new_tx_data`. It does not depend on `req_valid`.
- The stall counter is active only in PAYLOAD and only while `req_valid[cur_id]` is low. It does not count while `tx_busy` stalls the channel.
- Simultaneous `req_last` and count==`MAX_LEN`: treated as a normal end, so `pkt_done` pulses.
- Simultaneous valid&ready and timeout: the byte is accepted and the timeout is ignored.

## Test plan
- Single packet: req0 sends 0x11, 0x22 (last), `tx_busy`=0.
  - Strobes 0xA0, 0x11, 0x22, 0x93, spaced 2 cycles.
  - `pkt_done` pulses with the 0x93 strobe.
- Round-robin: req0..req3 all valid from reset, each sending a 1-byte packet.
  - Headers in order 0xA0, 0xA1, 0xA2, 0xA3.
  - Re-asserting req0 with req2 valid after req1 finishes → 0xA2 precedes 0xA0.
- Back-pressure: `tx_busy` held high for 100 cycles after the header.
  - No strobe and `req_ready`=0 during those cycles.
  - The payload byte is emitted 1 cycle after `tx_busy` falls, with no loss.
- Stall abort (`TIMEOUT`=20): req1 sends 0x55, then drops `req_valid`.
  - After 20 cycles, trailer ~(0xA1^0x55)=0x0B is strobed with `pkt_abort`.
  - `grant` returns to 0.
- Truncation (`MAX_LEN`=4): req2 streams 6 bytes without `req_last`.
  - Frame is header, 4 bytes, checksum, then `pkt_done`.
  - Next frame is 0xA2 with the remaining 2 bytes.
- Async reset asserted mid-payload:
  - Outputs clear immediately, with no trailer.
  - After release, req0 wins first.
